// File: rtl/obi_mem_slave.sv
// -----------------------------------------------------------------------------
// obi_mem_slave
//
// Memory slave that answers a core's instruction-fetch and data req/gnt/rvalid
// ports. Both ports share one word-addressed array. Each port has its own grant
// delay and response latency, so stalled and back-to-back traffic are produced
// without hand-timed stimulus. A backdoor write port preloads programs.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   instr_req_i/gnt_o      fetch handshake; instr_addr_i is a byte address
//   instr_rvalid_o/rdata_o fetch response (NOP for out-of-range addresses)
//   data_req_i/gnt_o       data handshake; data_we_i 1=store, 0=load
//   data_be_i/wdata_i      store byte enables (bit n = lane n) and data
//   data_rvalid_o/rdata_o  load/store response; data_err_o flags out of range
//   ld_we_i/addr_i/wdata_i backdoor word write (wins over a same-cycle store)
// -----------------------------------------------------------------------------
module obi_mem_slave #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned I_GNT_DELAY = 0,
    parameter int unsigned I_RESP_LAT  = 1,
    parameter int unsigned D_GNT_DELAY = 0,
    parameter int unsigned D_RESP_LAT  = 1,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          rst_ni,

    input  logic          instr_req_i,
    output logic          instr_gnt_o,
    output logic          instr_rvalid_o,
    input  logic [31:0]   instr_addr_i,
    output logic [31:0]   instr_rdata_o,

    input  logic          data_req_i,
    output logic          data_gnt_o,
    output logic          data_rvalid_o,
    input  logic          data_we_i,
    input  logic [3:0]    data_be_i,
    input  logic [31:0]   data_addr_i,
    input  logic [31:0]   data_wdata_i,
    output logic [31:0]   data_rdata_o,
    output logic          data_err_o,

    input  logic          ld_we_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [31:0]   ld_wdata_i
);

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
    } i_resp_t;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } d_resp_t;

    logic [31:0] mem [DEPTH_WORDS];

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    logic [AW-1:0] i_idx;
    logic [AW-1:0] d_idx;
    logic          i_in_range;
    logic          d_in_range;

    assign i_idx      = instr_addr_i[AW+1:2];
    assign d_idx      = data_addr_i[AW+1:2];
    assign i_in_range = ({2'b00, instr_addr_i[31:2]} < 32'(DEPTH_WORDS));
    assign d_in_range = ({2'b00, data_addr_i[31:2]} < 32'(DEPTH_WORDS));

    // Sub-word address bits carry no meaning for a word memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{instr_addr_i[1:0], data_addr_i[1:0]};

    // -------------------------------------------------------------------------
    // Grant generation. The wait counter advances while a request is stalled
    // and clears on idle or accept, so a held request is granted once every
    // GNT_DELAY+1 cycles. Grant is forced low while reset is asserted even when
    // the delay is zero and gnt would otherwise be combinational from req.
    // -------------------------------------------------------------------------
    logic [3:0] i_cnt_reg;
    logic [3:0] d_cnt_reg;
    logic       i_accept;
    logic       d_accept;

    assign instr_gnt_o = rst_ni & instr_req_i & (i_cnt_reg == 4'(I_GNT_DELAY));
    assign data_gnt_o  = rst_ni & data_req_i  & (d_cnt_reg == 4'(D_GNT_DELAY));
    assign i_accept    = instr_req_i & instr_gnt_o;
    assign d_accept    = data_req_i  & data_gnt_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            i_cnt_reg <= '0;
        end else if (!instr_req_i || i_accept) begin
            i_cnt_reg <= '0;
        end else begin
            i_cnt_reg <= i_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_cnt_reg <= '0;
        end else if (!data_req_i || d_accept) begin
            d_cnt_reg <= '0;
        end else begin
            d_cnt_reg <= d_cnt_reg + 4'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Memory writes. The backdoor write is issued last so that, on a same-word
    // collision, it overrides the byte lanes of a data store. Reads of the
    // same word in that cycle return the pre-edge contents.
    // -------------------------------------------------------------------------
    logic d_store;
    assign d_store = d_accept & data_we_i & d_in_range;

    always_ff @(posedge clk_i) begin
        if (d_store) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem[d_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
        if (ld_we_i) begin
            mem[ld_addr_i] <= ld_wdata_i;
        end
    end

    // -------------------------------------------------------------------------
    // Response pipelines. Stage 0 is loaded at the accept edge; an idle slot
    // is all-zero, which keeps rdata/err at 0 whenever rvalid is low.
    // -------------------------------------------------------------------------
    i_resp_t i_pipe_reg [I_RESP_LAT];
    d_resp_t d_pipe_reg [D_RESP_LAT];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < int'(I_RESP_LAT); s++) begin
                i_pipe_reg[s] <= '0;
            end
        end else begin
            if (i_accept) begin
                i_pipe_reg[0].valid <= 1'b1;
                i_pipe_reg[0].rdata <= i_in_range ? mem[i_idx] : NOP_INSN;
            end else begin
                i_pipe_reg[0] <= '0;
            end
            for (int s = 1; s < int'(I_RESP_LAT); s++) begin
                i_pipe_reg[s] <= i_pipe_reg[s-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < int'(D_RESP_LAT); s++) begin
                d_pipe_reg[s] <= '0;
            end
        end else begin
            if (d_accept) begin
                d_pipe_reg[0].valid <= 1'b1;
                d_pipe_reg[0].err   <= ~d_in_range;
                // Stores and out-of-range accesses answer with zero data.
                d_pipe_reg[0].rdata <= (d_in_range && !data_we_i) ? mem[d_idx] : 32'h0;
            end else begin
                d_pipe_reg[0] <= '0;
            end
            for (int s = 1; s < int'(D_RESP_LAT); s++) begin
                d_pipe_reg[s] <= d_pipe_reg[s-1];
            end
        end
    end

    assign instr_rvalid_o = i_pipe_reg[I_RESP_LAT-1].valid;
    assign instr_rdata_o  = i_pipe_reg[I_RESP_LAT-1].rdata;
    assign data_rvalid_o  = d_pipe_reg[D_RESP_LAT-1].valid;
    assign data_err_o     = d_pipe_reg[D_RESP_LAT-1].err;
    assign data_rdata_o   = d_pipe_reg[D_RESP_LAT-1].rdata;

endmodule

// File: tb/tb_obi_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_obi_mem_slave
//
// Two slave instances share one clock: dut_a uses the default timing
// (grant delay 0, latency 1 on both ports), dut_b uses instr delay 2 /
// latency 3 and data delay 1 / latency 4. Each accepted request pushes its
// expected response and due cycle onto a scoreboard; a negedge monitor pops
// and compares, and flags any response that is missing, early, late or
// unexpected.
// -----------------------------------------------------------------------------
module tb_obi_mem_slave;

    localparam int AW = 10;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]          rst_n;
    logic [1:0]          instr_req;
    logic [1:0][31:0]    instr_addr;
    logic [1:0]          instr_gnt;
    logic [1:0]          instr_rvalid;
    logic [1:0][31:0]    instr_rdata;
    logic [1:0]          data_req;
    logic [1:0]          data_we;
    logic [1:0][3:0]     data_be;
    logic [1:0][31:0]    data_addr;
    logic [1:0][31:0]    data_wdata;
    logic [1:0]          data_gnt;
    logic [1:0]          data_rvalid;
    logic [1:0][31:0]    data_rdata;
    logic [1:0]          data_err;
    logic [1:0]          ld_we;
    logic [1:0][AW-1:0]  ld_addr;
    logic [1:0][31:0]    ld_wdata;

    obi_mem_slave #(
        .DEPTH_WORDS(1024), .I_GNT_DELAY(0), .I_RESP_LAT(1),
        .D_GNT_DELAY(0), .D_RESP_LAT(1)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n[0]),
        .instr_req_i(instr_req[0]), .instr_gnt_o(instr_gnt[0]),
        .instr_rvalid_o(instr_rvalid[0]), .instr_addr_i(instr_addr[0]),
        .instr_rdata_o(instr_rdata[0]),
        .data_req_i(data_req[0]), .data_gnt_o(data_gnt[0]),
        .data_rvalid_o(data_rvalid[0]), .data_we_i(data_we[0]),
        .data_be_i(data_be[0]), .data_addr_i(data_addr[0]),
        .data_wdata_i(data_wdata[0]), .data_rdata_o(data_rdata[0]),
        .data_err_o(data_err[0]),
        .ld_we_i(ld_we[0]), .ld_addr_i(ld_addr[0]), .ld_wdata_i(ld_wdata[0])
    );

    obi_mem_slave #(
        .DEPTH_WORDS(1024), .I_GNT_DELAY(2), .I_RESP_LAT(3),
        .D_GNT_DELAY(1), .D_RESP_LAT(4)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n[1]),
        .instr_req_i(instr_req[1]), .instr_gnt_o(instr_gnt[1]),
        .instr_rvalid_o(instr_rvalid[1]), .instr_addr_i(instr_addr[1]),
        .instr_rdata_o(instr_rdata[1]),
        .data_req_i(data_req[1]), .data_gnt_o(data_gnt[1]),
        .data_rvalid_o(data_rvalid[1]), .data_we_i(data_we[1]),
        .data_be_i(data_be[1]), .data_addr_i(data_addr[1]),
        .data_wdata_i(data_wdata[1]), .data_rdata_o(data_rdata[1]),
        .data_err_o(data_err[1]),
        .ld_we_i(ld_we[1]), .ld_addr_i(ld_addr[1]), .ld_wdata_i(ld_wdata[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard entry; ch = 2*dut + (0 instr, 1 data).
    typedef struct {
        int          ch;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[11];

    function automatic int i_lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int d_lat(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drop_channel(input int ch);
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].ch == ch) sb.delete(k);
        end
    endtask

    // Response monitor: exactly one rvalid per due cycle, idle outputs zero.
    always @(negedge clk) begin : monitor
        int          idx;
        int          d;
        logic        v;
        logic        e;
        logic [31:0] rd;
        if (mon_en) begin
            for (int ch = 0; ch < 4; ch++) begin
                d = ch >> 1;
                if (ch[0]) begin
                    v = data_rvalid[d]; rd = data_rdata[d]; e = data_err[d];
                end else begin
                    v = instr_rvalid[d]; rd = instr_rdata[d]; e = 1'b0;
                end
                idx = -1;
                for (int k = 0; k < sb.size(); k++) begin
                    if (sb[k].ch == ch) begin
                        idx = k;
                        break;
                    end
                end
                checks++;
                if (idx >= 0 && sb[idx].due == cyc) begin
                    if (v !== 1'b1 || rd !== sb[idx].rdata || e !== sb[idx].err) begin
                        errors++;
                        $display("FAIL resp ch%0d cyc %0d: rvalid=%0b rdata=%h err=%0b, expected rvalid=1 rdata=%h err=%0b",
                                 ch, cyc, v, rd, e, sb[idx].rdata, sb[idx].err);
                    end
                    sb.delete(idx);
                end else if (v !== 1'b0 || rd !== 32'h0 || e !== 1'b0) begin
                    errors++;
                    $display("FAIL idle ch%0d cyc %0d: rvalid=%0b rdata=%h err=%0b, expected all 0",
                             ch, cyc, v, rd, e);
                end
            end
        end
    end

    // Issue one fetch; call at posedge+1. With hold=1 req stays high for the
    // next back-to-back request.
    task automatic fetch(input int d, input logic [31:0] addr, input logic [31:0] exp,
                         input bit hold, output int waited);
        exp_t ent;
        bit   granted;
        instr_req[d]  = 1'b1;
        instr_addr[d] = addr;
        waited  = 0;
        granted = 1'b0;
        while (!granted && waited <= 40) begin
            @(negedge clk);
            if (instr_gnt[d]) granted = 1'b1;
            else waited++;
        end
        if (granted) begin
            ent.ch = 2 * d; ent.rdata = exp; ent.err = 1'b0; ent.due = cyc + i_lat(d);
            sb.push_back(ent);
        end else begin
            checks++; errors++;
            $display("FAIL fetch_gnt_timeout dut%0d addr %h: got no grant, expected grant", d, addr);
        end
        @(posedge clk); #1;
        if (!hold || !granted) instr_req[d] = 1'b0;
    endtask

    task automatic data_xfer(input int d, input logic we, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp, input logic exp_err,
                             input bit hold, output int waited);
        exp_t ent;
        bit   granted;
        data_req[d]   = 1'b1;
        data_we[d]    = we;
        data_be[d]    = be;
        data_addr[d]  = addr;
        data_wdata[d] = wdata;
        waited  = 0;
        granted = 1'b0;
        while (!granted && waited <= 40) begin
            @(negedge clk);
            if (data_gnt[d]) granted = 1'b1;
            else waited++;
        end
        if (granted) begin
            ent.ch = 2 * d + 1; ent.rdata = exp; ent.err = exp_err; ent.due = cyc + d_lat(d);
            sb.push_back(ent);
        end else begin
            checks++; errors++;
            $display("FAIL data_gnt_timeout dut%0d addr %h: got no grant, expected grant", d, addr);
        end
        @(posedge clk); #1;
        if (!hold || !granted) data_req[d] = 1'b0;
    endtask

    task automatic preload_both(input logic [AW-1:0] idx, input logic [31:0] val);
        ld_we    = 2'b11;
        ld_addr  = {idx, idx};
        ld_wdata = {val, val};
        @(posedge clk); #1;
        ld_we    = 2'b00;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int w;
        int w2;

        vecs[0]  = '{1'b1, 4'b0101, 32'h0000_000C, 32'hAABB_CCDD, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 4'b1111, 32'h0000_000C, 32'h0,         32'h00BB_00DD, 1'b0};
        vecs[2]  = '{1'b0, 4'b1111, 32'h0000_1000, 32'h0,         32'h0000_0000, 1'b1};
        vecs[3]  = '{1'b1, 4'b1111, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
        vecs[4]  = '{1'b0, 4'b1111, 32'h0000_0000, 32'h0,         32'h0030_0293, 1'b0};
        vecs[5]  = '{1'b1, 4'b0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[6]  = '{1'b0, 4'b1111, 32'h0000_0003, 32'h0,         32'h0030_0293, 1'b0};
        vecs[7]  = '{1'b0, 4'b1111, 32'h0000_0FFC, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[8]  = '{1'b1, 4'b1000, 32'h0000_0004, 32'h5A00_0000, 32'h0000_0000, 1'b0};
        vecs[9]  = '{1'b0, 4'b1111, 32'h0000_0006, 32'h0,         32'h5A70_0313, 1'b0};
        vecs[10] = '{1'b0, 4'b1111, 32'hFFFF_FFFC, 32'h0,         32'h0000_0000, 1'b1};

        rst_n = 2'b00;
        instr_req = 2'b11; instr_addr = '0;
        data_req = 2'b11; data_we = '0; data_be = '0; data_addr = '0; data_wdata = '0;
        ld_we = '0; ld_addr = '0; ld_wdata = '0;

        // Reset state: grants held low even with req high and zero delay.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst instr_gnt_a", {31'h0, instr_gnt[0]}, 32'h0);
        check("rst data_gnt_a", {31'h0, data_gnt[0]}, 32'h0);
        check("rst rvalid", {28'h0, instr_rvalid, data_rvalid}, 32'h0);
        check("rst data_err", {30'h0, data_err}, 32'h0);
        check("rst instr_rdata_a", instr_rdata[0], 32'h0);
        check("rst data_rdata_a", data_rdata[0], 32'h0);
        instr_req = 2'b00; data_req = 2'b00;
        @(posedge clk); #1;
        rst_n  = 2'b11;
        mon_en = 1'b1;

        preload_both(10'd0, 32'h0030_0293);
        preload_both(10'd1, 32'h0070_0313);
        preload_both(10'd2, 32'h0062_83B3);
        preload_both(10'd3, 32'h0000_0000);
        preload_both(10'd4, 32'h1111_1111);
        preload_both(10'd6, 32'h1818_1818);
        preload_both(10'd1023, 32'hCAFE_F00D);

        // Back-to-back fetches, zero delay: grant each request cycle.
        fetch(0, 32'h0, 32'h0030_0293, 1'b1, w); check("a fetch0 wait", w, 0);
        fetch(0, 32'h4, 32'h0070_0313, 1'b1, w); check("a fetch1 wait", w, 0);
        fetch(0, 32'h8, 32'h0062_83B3, 1'b0, w); check("a fetch2 wait", w, 0);
        fetch(0, 32'h1000, 32'h0000_0013, 1'b0, w); check("a fetch oor wait", w, 0);

        // Delay 2 / latency 3: grant in 3rd req cycle, one grant per 3 cycles.
        fetch(1, 32'h4, 32'h0070_0313, 1'b1, w); check("b fetch0 wait", w, 2);
        fetch(1, 32'h4, 32'h0070_0313, 1'b1, w); check("b fetch1 wait", w, 2);
        fetch(1, 32'h8, 32'h0062_83B3, 1'b0, w); check("b fetch2 wait", w, 2);

        // Data-port vector table, issued back to back.
        for (int i = 0; i < 11; i++) begin
            data_xfer(0, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata,
                      vecs[i].exp_rdata, vecs[i].exp_err, (i < 10), w);
            check($sformatf("a vec%0d wait", i), w, 0);
        end

        // Same-cycle fetch and store on one word: fetch sees the old value.
        fork
            fetch(0, 32'h10, 32'h1111_1111, 1'b0, w);
            data_xfer(0, 1'b1, 4'b1111, 32'h10, 32'h1234_5678, 32'h0, 1'b0, 1'b0, w2);
        join
        check("a coll fetch wait", w, 0);
        check("a coll store wait", w2, 0);
        fetch(0, 32'h10, 32'h1234_5678, 1'b0, w);

        // Backdoor write beats a same-cycle store; the store still responds.
        fork
            data_xfer(0, 1'b1, 4'b1111, 32'h14, 32'hDEAD_0000, 32'h0, 1'b0, 1'b0, w);
            begin
                ld_we[0] = 1'b1; ld_addr[0] = 10'd5; ld_wdata[0] = 32'h7777_7777;
                @(posedge clk); #1;
                ld_we[0] = 1'b0;
            end
        join
        data_xfer(0, 1'b0, 4'b1111, 32'h14, 32'h0, 32'h7777_7777, 1'b0, 1'b0, w);

        // Backdoor write during reads of the same word: reads see old value.
        fork
            fetch(0, 32'h18, 32'h1818_1818, 1'b0, w);
            data_xfer(0, 1'b0, 4'b1111, 32'h18, 32'h0, 32'h1818_1818, 1'b0, 1'b0, w2);
            begin
                ld_we[0] = 1'b1; ld_addr[0] = 10'd6; ld_wdata[0] = 32'h9999_9999;
                @(posedge clk); #1;
                ld_we[0] = 1'b0;
            end
        join
        fetch(0, 32'h18, 32'h9999_9999, 1'b0, w);

        // Reset with two loads in flight on the latency-4 data port.
        data_xfer(1, 1'b1, 4'b1111, 32'h20, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0, w);
        check("b store wait", w, 1);
        repeat (6) @(posedge clk);
        #1;
        data_xfer(1, 1'b0, 4'b1111, 32'h20, 32'h0, 32'hA5A5_A5A5, 1'b0, 1'b1, w);
        check("b load0 wait", w, 1);
        data_xfer(1, 1'b0, 4'b1111, 32'h0, 32'h0, 32'h0030_0293, 1'b0, 1'b0, w);
        check("b load1 wait", w, 1);
        check("b in-flight before reset", sb.size(), 2);
        drop_channel(3);
        rst_n[1] = 1'b0;
        #1;
        check("b rst gnt", {30'h0, instr_gnt[1], data_gnt[1]}, 32'h0);
        check("b rst rvalid", {30'h0, instr_rvalid[1], data_rvalid[1]}, 32'h0);
        check("b rst data_err", {31'h0, data_err[1]}, 32'h0);
        check("b rst instr_rdata", instr_rdata[1], 32'h0);
        check("b rst data_rdata", data_rdata[1], 32'h0);
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        data_xfer(1, 1'b0, 4'b1111, 32'h20, 32'h0, 32'hA5A5_A5A5, 1'b0, 1'b0, w);
        check("b post-rst load wait", w, 1);

        // Zero-delay port held in reset with req high: no grant until release.
        instr_req[0] = 1'b1; instr_addr[0] = 32'h0;
        data_req[0] = 1'b1; data_we[0] = 1'b0; data_addr[0] = 32'h0;
        rst_n[0] = 1'b0;
        #1;
        check("a rst instr_gnt", {31'h0, instr_gnt[0]}, 32'h0);
        check("a rst data_gnt", {31'h0, data_gnt[0]}, 32'h0);
        @(posedge clk); #1;
        instr_req[0] = 1'b0; data_req[0] = 1'b0;
        rst_n[0] = 1'b1;
        fetch(0, 32'h8, 32'h0062_83B3, 1'b0, w);
        check("a post-rst fetch wait", w, 0);

        repeat (10) @(posedge clk);
        #1;
        check("scoreboard drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
